// File: rtl/mod_add_const_rr_arb_if.sv
// rtl/mod_add_const_rr_arb_if.sv - request/result handshake bundle for the shared modular adder
interface mod_add_const_rr_arb_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned OPA_WIDTH = 18,
  parameter int unsigned TAG_W     = $clog2(NUM_REQ)
) ();

  // Requester side: one valid/ready pair per digit lane, operands packed by lane index.
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*OPA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;

  // Result side: single stream tagged with the owning lane.
  logic                         out_valid;
  logic                         out_ready;
  logic [TAG_W-1:0]             out_tag;
  logic [OPA_WIDTH-1:0]         out_data;

  // Lane/consumer view: drives requests and result backpressure.
  modport master (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_tag,
    input  out_data
  );

  // Shared-adder view.
  modport slave (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_tag,
    output out_data
  );

endinterface

// File: rtl/mod_add_const_rr_arb.sv
// rtl/mod_add_const_rr_arb.sv - round-robin shared two-stage (a + CONST) mod MODULUS datapath
module mod_add_const_rr_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned OPA_WIDTH = 18,
  parameter int unsigned OUT_WIDTH = 19,
  parameter int unsigned CONST     = 0,
  parameter int unsigned MODULUS   = 262139,
  localparam int unsigned TAG_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mod_add_const_rr_arb_if.slave   bus
);

  // Stage 1: raw sum and owning lane.
  logic                 s1_valid_q, s1_valid_d;
  logic [OUT_WIDTH-1:0] s1_sum_q,   s1_sum_d;
  logic [TAG_W-1:0]     s1_tag_q,   s1_tag_d;

  // Stage 2: reduced result presented on the output stream.
  logic                 out_valid_q, out_valid_d;
  logic [OPA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [TAG_W-1:0]     out_tag_q,   out_tag_d;

  // Round-robin pointer: lane that gets first look on the next accept.
  logic [TAG_W-1:0]     ptr_q, ptr_d;

  // Arbitration and flow-control nets.
  logic                 adv;
  logic                 s1_load_ok;
  logic                 grant_any;
  logic [TAG_W-1:0]     winner;
  logic                 accept;
  logic [NUM_REQ-1:0]   grant_oh;

  logic [OPA_WIDTH-1:0] req_op [NUM_REQ];

  // Lane index arithmetic modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [TAG_W-1:0] rr_add(input logic [TAG_W-1:0] base,
                                              input logic [TAG_W:0]   off);
    logic [TAG_W:0] s;
    s = {1'b0, base} + off;
    if (s >= (TAG_W+1)'(NUM_REQ)) begin
      s = s - (TAG_W+1)'(NUM_REQ);
    end
    return s[TAG_W-1:0];
  endfunction

  // Unpack the flat operand bus into one word per lane.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_op
      assign req_op[gi] = bus.req_data[gi*OPA_WIDTH +: OPA_WIDTH];
    end
  endgenerate

  // Output stage moves whenever its content is consumed or it holds nothing;
  // stage 1 may refill when empty even if the output is stalled (bubble collapse).
  assign adv        = bus.out_ready | ~out_valid_q;
  assign s1_load_ok = ~s1_valid_q | adv;

  // Round-robin search: first valid lane starting at ptr and wrapping around.
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!grant_any && bus.req_valid[rr_add(ptr_q, (TAG_W+1)'(k))]) begin
        grant_any = 1'b1;
        winner    = rr_add(ptr_q, (TAG_W+1)'(k));
      end
    end
  end

  assign accept = grant_any & s1_load_ok;

  // One-hot accept strobe toward the lanes.
  always_comb begin
    grant_oh = '0;
    if (accept) begin
      grant_oh[winner] = 1'b1;
    end
  end

  // Ready is forced low while reset is asserted so no lane sees a phantom accept.
  assign bus.req_ready = rst_n ? grant_oh : '0;

  // Next-state for the pointer: step past the lane just served, otherwise hold.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = rr_add(winner, (TAG_W+1)'(1));
    end
  end

  // Next-state for stage 1: load on accept, drain when passing into stage 2, else hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_tag_d   = s1_tag_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_sum_d   = OUT_WIDTH'(req_op[winner]) + OUT_WIDTH'(CONST);
      s1_tag_d   = winner;
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Next-state for stage 2: a single conditional subtract reduces any in-range sum.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      out_tag_d   = s1_tag_q;
      out_data_d  = OPA_WIDTH'((s1_sum_q >= OUT_WIDTH'(MODULUS))
                               ? (s1_sum_q - OUT_WIDTH'(MODULUS))
                               : s1_sum_q);
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_tag_q    <= s1_tag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_mod_add_const_rr_arb.sv
// tb/tb_mod_add_const_rr_arb.sv - self-checking bench for mod_add_const_rr_arb
module tb_mod_add_const_rr_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned OW = 18;
  localparam int unsigned SW = 19;
  localparam int unsigned CK = 5;
  localparam int unsigned MD = 262139;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mod_add_const_rr_arb_if #(.NUM_REQ(NR), .OPA_WIDTH(OW)) bus ();

  mod_add_const_rr_arb #(
    .NUM_REQ(NR), .OPA_WIDTH(OW), .OUT_WIDTH(SW), .CONST(CK), .MODULUS(MD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int unsigned lane;
    int unsigned a;
    int unsigned exp;
  } vec_t;

  typedef struct {
    int unsigned tag;
    int unsigned data;
  } exp_t;

  vec_t        vt [6];
  exp_t        sb [$];
  exp_t        e;
  int unsigned tq [$];
  int unsigned dq [$];
  logic        lv [NR];
  int unsigned ld [NR];
  int unsigned wait_n [NR];
  logic [NR-1:0] acc_v;
  logic [NR-1:0] oh;
  int          checks = 0;
  int          errors = 0;
  int          acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_lane(input int unsigned l, input int unsigned d);
    bus.req_data[l*OW +: OW] = OW'(d);
  endtask

  task automatic pop_cmp(input string name);
    if (sb.size() == 0) begin
      chk({name, "_unexpected"}, 32'(bus.out_valid), 32'(0));
    end else begin
      e = sb.pop_front();
      chk({name, "_tag"},  32'(bus.out_tag),  e.tag);
      chk({name, "_data"}, 32'(bus.out_data), e.data);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    do_reset();

    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_tag",   32'(bus.out_tag),   32'(0));
    chk("rst_out_data",  32'(bus.out_data),  32'(0));
    chk("rst_ptr",       32'(dut.ptr_q),     32'(0));

    // Single-request vectors, including the reduction boundary.
    vt[0] = '{2, 100,    105};
    vt[1] = '{1, 262136, 2};
    vt[2] = '{3, 262133, 262138};
    vt[3] = '{0, 0,      5};
    vt[4] = '{0, 262134, 0};
    vt[5] = '{3, 262138, 4};
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = '0;
      bus.req_valid[vt[i].lane] = 1'b1;
      set_lane(vt[i].lane, vt[i].a);
      oh = '0;
      oh[vt[i].lane] = 1'b1;
      #1;
      chk("vec_ready", 32'(bus.req_ready), 32'(oh));
      step();
      bus.req_valid = '0;
      chk("vec_lat1_valid", 32'(bus.out_valid), 32'(0));
      step();
      chk("vec_valid", 32'(bus.out_valid), 32'(1));
      chk("vec_tag",   32'(bus.out_tag),   vt[i].lane);
      chk("vec_data",  32'(bus.out_data),  vt[i].exp);
    end

    // Round robin from ptr=0 with every lane asserting.
    do_reset();
    for (int l = 0; l < int'(NR); l++) set_lane(l, l*1000 + 7);
    bus.req_valid = '1;
    bus.out_ready = 1'b1;
    tq.delete();
    dq.delete();
    repeat (8) begin
      step();
      if (bus.out_valid) begin
        tq.push_back(32'(bus.out_tag));
        dq.push_back(32'(bus.out_data));
      end
    end
    chk("rr_count", 32'(tq.size() >= 6), 32'(1));
    if (tq.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("rr_tag",  tq[i], i % 4);
        chk("rr_data", dq[i], (i % 4)*1000 + 7 + CK);
      end
    end

    // Asynchronous reset in the middle of a full pipeline.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("async_rst_ready",     32'(bus.req_ready), 32'(0));
    chk("async_rst_ptr",       32'(dut.ptr_q),     32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_valid = '0;

    // Move ptr to 3 by serving lane 2 alone, then rerun with all lanes.
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    chk("rr2_ptr", 32'(dut.ptr_q), 32'(3));
    step();
    step();
    tq.delete();
    bus.req_valid = '1;
    repeat (6) begin
      step();
      if (bus.out_valid) tq.push_back(32'(bus.out_tag));
    end
    chk("rr2_count", 32'(tq.size() >= 4), 32'(1));
    if (tq.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr2_tag", tq[i], (i + 3) % 4);
    end

    // Backpressure: output stalled, all lanes asserting.
    do_reset();
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (|(bus.req_valid & bus.req_ready)) acc++;
      step();
      if (c >= 1) begin
        chk("bp_valid", 32'(bus.out_valid), 32'(1));
        chk("bp_tag",   32'(bus.out_tag),   32'(0));
        chk("bp_data",  32'(bus.out_data),  32'(7 + CK));
      end
    end
    chk("bp_accepts", 32'(acc), 32'(2));
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    tq.delete();
    dq.delete();
    repeat (5) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        tq.push_back(32'(bus.out_tag));
        dq.push_back(32'(bus.out_data));
      end
      step();
    end
    chk("bp_drain_count", 32'(tq.size()), 32'(2));
    if (tq.size() == 2) begin
      chk("bp_drain_tag0",  tq[0], 0);
      chk("bp_drain_data0", dq[0], 7 + CK);
      chk("bp_drain_tag1",  tq[1], 1);
      chk("bp_drain_data1", dq[1], 1007 + CK);
    end

    // Random traffic against a scoreboard.
    do_reset();
    sb.delete();
    for (int l = 0; l < int'(NR); l++) begin
      lv[l] = 1'b0;
      ld[l] = 0;
      wait_n[l] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int l = 0; l < int'(NR); l++) begin
        if (!lv[l] && ($urandom_range(0, 1) == 1)) begin
          lv[l] = 1'b1;
          if ($urandom_range(0, 3) == 0) ld[l] = MD - 1 - $urandom_range(0, 7);
          else ld[l] = $urandom_range(0, MD - 1);
        end
        bus.req_valid[l] = lv[l];
        set_lane(l, ld[l]);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #2;
      chk("rand_onehot", 32'($onehot0(bus.req_ready)), 32'(1));
      if (bus.out_valid && bus.out_ready) pop_cmp("rand");
      acc_v = bus.req_valid & bus.req_ready;
      if (|acc_v) begin
        for (int l = 0; l < int'(NR); l++) begin
          if (acc_v[l]) begin
            chk("rand_starve", 32'(wait_n[l] <= NR - 1), 32'(1));
            sb.push_back('{l, (ld[l] + CK) % MD});
            lv[l] = 1'b0;
            wait_n[l] = 0;
          end else if (lv[l]) begin
            wait_n[l]++;
          end
        end
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (bus.out_valid) pop_cmp("drain");
      @(posedge clk);
      #1;
    end
    chk("rand_sb_empty", 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
